// File: rtl/pipe_stage_reg_if.sv
// Handshake bundle between two pipeline stages. The master side drives the
// upstream beat and downstream ready; the slave side is the stage register.
interface pipe_stage_reg_if #(
  parameter int DATA_WIDTH = 16,
  parameter int CTRL_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic [CTRL_WIDTH-1:0] in_ctrl;
  logic                  flush;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic [CTRL_WIDTH-1:0] out_ctrl;
  logic [CNT_WIDTH-1:0]  stall_count;

  modport master (
    output in_valid, in_data, in_ctrl, flush, out_ready,
    input  in_ready, out_valid, out_data, out_ctrl, stall_count
  );

  modport slave (
    input  in_valid, in_data, in_ctrl, flush, out_ready,
    output in_ready, out_valid, out_data, out_ctrl, stall_count
  );
endinterface

// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register: main + skid entry, registered in_ready,
// synchronous flush, NOP-gated control on bubbles and a saturating stall counter.
module pipe_stage_reg #(
  parameter int DATA_WIDTH = 16,
  parameter int CTRL_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input logic clk,
  input logic reset,
  pipe_stage_reg_if.slave bus
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t                state_q, state_d;
  logic                  in_ready_q, in_ready_d;
  logic [DATA_WIDTH-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d;
  logic [CTRL_WIDTH-1:0] main_ctrl_q, main_ctrl_d, skid_ctrl_q, skid_ctrl_d;
  logic [CNT_WIDTH-1:0]  stall_q, stall_d;
  logic                  out_valid;
  logic                  in_fire;
  logic                  out_fire;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  endfunction

  assign out_valid = (state_q != EMPTY);
  assign in_fire   = bus.in_valid & in_ready_q;
  assign out_fire  = out_valid & bus.out_ready;

  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_ctrl_d = main_ctrl_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;
    case (state_q)
      EMPTY: begin
        if (in_fire) begin
          main_data_d = bus.in_data;
          main_ctrl_d = bus.in_ctrl;
          state_d     = ONE;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          main_data_d = bus.in_data;
          main_ctrl_d = bus.in_ctrl;
        end else if (out_fire) begin
          state_d = EMPTY;
        end else if (in_fire) begin
          skid_data_d = bus.in_data;
          skid_ctrl_d = bus.in_ctrl;
          state_d     = FULL;
        end
      end
      FULL: begin
        // in_ready is low here, so only the drain path can move
        if (out_fire) begin
          main_data_d = skid_data_q;
          main_ctrl_d = skid_ctrl_q;
          state_d     = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (bus.flush) state_d = EMPTY;
    in_ready_d = (state_d != FULL);
    stall_d    = (out_valid && !bus.out_ready) ? sat_inc(stall_q) : stall_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= EMPTY;
      in_ready_q  <= 1'b0;
      main_data_q <= '0;
      main_ctrl_q <= '0;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
      stall_q     <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      main_data_q <= main_data_d;
      main_ctrl_q <= main_ctrl_d;
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      stall_q     <= stall_d;
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid;
  assign bus.out_data    = main_data_q;
  assign bus.out_ctrl    = out_valid ? main_ctrl_q : '0;
  assign bus.stall_count = stall_q;

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised successor to the fixed-width stage flip-flops between LC-3b pipeline stages: a single generic stage register with valid/ready handshake, a 2-entry skid buffer, synchronous flush and a stall-cycle counter.
- Instantiated between IF/ID, ID/EX, EX/MEM and MEM/WB; lets stages stall (cache miss) or squash (branch taken) without losing or duplicating beats.
- Data and control payloads are separate buses so the control word can be forced to NOP on bubbles.

Parameters:
DATA_WIDTH, 16, width of in_data/out_data (concatenated lc3b_word/lc3b_reg payload, packed by the instantiating stage)
CTRL_WIDTH, 32, width of in_ctrl/out_ctrl (packed lc3b_control_word)
CNT_WIDTH, 16, width of stall_count

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous, active-high reset
in_valid  input  1  upstream beat present
in_ready  output  1  stage can accept a beat; registered
in_data  input  DATA_WIDTH  upstream data payload
in_ctrl  input  CTRL_WIDTH  upstream control word
flush  input  1  synchronous squash of all held beats
out_valid  output  1  beat presented downstream
out_ready  input  1  downstream accepts the beat
out_data  output  DATA_WIDTH  downstream data payload
out_ctrl  output  CTRL_WIDTH  downstream control word; all-zero (NOP) when out_valid=0
stall_count  output  CNT_WIDTH  saturating count of back-pressured cycles

Behaviour:
- Fire definitions: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Storage: main register (drives outputs) and skid register, each holding {data, ctrl}.
- States:
  - EMPTY: no beats held.
  - ONE: main valid.
  - FULL: main and skid valid.
- out_valid = (state != EMPTY).
- Transitions when flush=0:
  - EMPTY: in_fire -> main<=in, ONE; else stay.
  - ONE:
    - in_fire & out_fire -> main<=in, stay ONE.
    - out_fire only -> EMPTY.
    - in_fire only -> skid<=in, FULL.
    - neither -> hold.
  - FULL: in_ready=0, so in_fire is impossible. out_fire -> main<=skid, ONE; else hold.
- flush=1:
  - Highest priority: next state EMPTY.
  - Any input beat offered that cycle is dropped. It counts as accepted if in_ready=1; upstream must not retry it.
  - Main/skid contents need not be cleared.
- in_ready:
  - Flop with next value (next_state != FULL).
  - No combinational path from out_ready or in_valid to in_ready.
- Latency and throughput:
  - In EMPTY, in_fire at edge N gives out_valid=1 after edge N, i.e. 1 cycle of latency.
  - Full throughput of 1 beat/cycle when out_ready is held high.
- Ordering and stability:
  - Beats leave in acceptance order.
  - No beat is duplicated or lost except through flush.
  - While out_valid=1 & out_ready=0, out_data and out_ctrl are stable.
- out_ctrl is gated to 0 when out_valid=0. out_data is unconstrained when out_valid=0, except that it is 0 after reset.
- stall_count:
  - +1 on every edge where out_valid=1 & out_ready=0.
  - Saturates at 2^CNT_WIDTH-1.
  - Unaffected by flush; cleared only by reset.
- Reset (asynchronous, any time including mid-transfer):
  - state=EMPTY, out_valid=0, in_ready=0, main=0, skid=0, out_ctrl=0, out_data=0, stall_count=0.
  - in_ready rises to 1 on the first clock edge after reset deasserts.
- Simultaneous events:
  - flush with out_fire: the beat is considered delivered downstream (downstream sampled it); state still goes to EMPTY.
  - flush while FULL: both beats are discarded.
  - in_valid with in_ready=0: the beat is not taken; upstream must hold it.

Test Plan:
- Reset then stream: out_ready=1, send data 0x0001..0x0008 back-to-back -> out_data 0x0001..0x0008 on 8 consecutive cycles, 1 cycle behind input; in_ready stays 1; stall_count=0.
- Back-pressure:
  - Stimulus: stream 0x00A1, 0x00A2, 0x00A3 with out_ready=0 from cycle 1.
  - Required: 0x00A1 in main, 0x00A2 in skid, in_ready=0, 0x00A3 held upstream.
  - Release out_ready: 0x00A1, 0x00A2, 0x00A3 delivered in order with none lost.
  - stall_count equals the number of stalled cycles.
- Flush while FULL (main=0x1111, skid=0x2222) with in_valid carrying 0x3333 -> next cycle out_valid=0, out_ctrl=0; next accepted beat 0x4444 is the first one output.
- Bubble gating: idle with in_valid=0 -> out_valid=0 and out_ctrl=0 every cycle, even after a prior beat with in_ctrl=0xFFFFFFFF.
- Saturation: CNT_WIDTH=4, hold out_valid=1, out_ready=0 for 20 cycles -> stall_count stops at 15.
- Async reset asserted mid-edge-free interval while FULL -> out_valid, in_ready and stall_count go to 0 immediately without a clock edge; in_ready=1 one edge after deassertion.
